uart_transmitter: RTL and testbench

Serial transmit end of the UART. It reads the 8-bit Baud Rate Divisor register output and uses it to time each bit. It accepts parallel bytes through a one-deep holding register and shifts them out as 8N1 frames on the tx line: 1 start bit, 8 data bits LSB first, 1 stop bit. It sits between the bus-side data register and the serial pin. It is the consumer of the divisor and the transmit counterpart of the UART receiver.

---
 rtl/uart_transmitter.sv | 165 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter
// Purpose  : Serial transmit end of the UART. Accepts bytes through a
//            one-deep holding register and shifts them out as 8N1 frames
//            (start bit, DATA_BITS data bits LSB first, stop bit), with each
//            bit lasting 'divisor' clock cycles (clamped to MIN_DIVISOR).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1  system clock, rising edge
//   notreset   in   1  asynchronous active-low reset
//   enable     in   1  UART enable; 0 = finish current frame, then stay idle
//   divisor    in   8  clk cycles per serial bit
//   data       in   8  byte to transmit
//   load       in   1  write strobe for data
//   holdempty  out  1  holding register can accept a byte
//   busy       out  1  frame in progress
//   overrun    out  1  one-cycle pulse: load while holding register full
//   tx         out  1  serial line, idles high
// ============================================================================
module uart_transmitter #(
    parameter int DATA_BITS   = 8,
    parameter int MIN_DIVISOR = 5
) (
    input  logic                 clk,
    input  logic                 notreset,
    input  logic                 enable,
    input  logic [7:0]           divisor,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 load,
    output logic                 holdempty,
    output logic                 busy,
    output logic                 overrun,
    output logic                 tx
);

    localparam int                IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [7:0]        MIN_DIV  = 8'(MIN_DIVISOR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state;
    logic [DATA_BITS-1:0]   hold;
    logic [DATA_BITS-1:0]   shift;
    logic [7:0]             bitdiv;
    logic [7:0]             baud_cnt;
    logic [IDX_W-1:0]       bit_idx;

    logic                   wrap;
    logic                   start_now;
    logic [7:0]             div_clamped;

    // Last cycle of the current bit; bitdiv is never below MIN_DIV while a
    // frame is active, so the subtraction cannot underflow in use.
    assign wrap        = (baud_cnt == (bitdiv - 8'd1));
    assign div_clamped = (divisor >= MIN_DIV) ? divisor : MIN_DIV;

    // A new frame begins from IDLE, or back-to-back from the final cycle of
    // a stop bit, whenever a byte is waiting and the UART is enabled.
    assign start_now = enable && !holdempty &&
                       ((state == IDLE) || ((state == STOP) && wrap));

    always_ff @(posedge clk or negedge notreset) begin
        if (!notreset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            holdempty <= 1'b1;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            hold      <= '0;
            shift     <= '0;
            bitdiv    <= 8'd0;
            baud_cnt  <= 8'd0;
            bit_idx   <= '0;
        end else begin
            overrun <= 1'b0;

            // Holding register write. A load while full is dropped and
            // flagged, even if the held byte moves to the shifter this edge.
            if (load) begin
                if (holdempty) begin
                    hold      <= data;
                    holdempty <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= 8'd0;
                end

                START: begin
                    if (wrap) begin
                        baud_cnt <= 8'd0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end
                end

                DATA: begin
                    if (wrap) begin
                        baud_cnt <= 8'd0;
                        shift    <= {1'b0, shift[DATA_BITS-1:1]};
                        if (bit_idx == LAST_IDX) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // tx leads the shift register by one bit so the
                            // output stays registered.
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end
                end

                STOP: begin
                    if (wrap) begin
                        baud_cnt <= 8'd0;
                        tx       <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase

            // Frame launch overrides the state-local updates above.
            if (start_now) begin
                state     <= START;
                shift     <= hold;
                holdempty <= 1'b1;
                bitdiv    <= div_clamped;
                baud_cnt  <= 8'd0;
                bit_idx   <= '0;
                tx        <= 1'b0;
                busy      <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_transmitter
// Purpose  : Directed self-checking bench for uart_transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       notreset;
    logic       enable;
    logic [7:0] divisor;
    logic [7:0] data;
    logic       load;
    logic       holdempty;
    logic       busy;
    logic       overrun;
    logic       tx;

    int errors = 0;
    int checks = 0;

    uart_transmitter #(
        .DATA_BITS   (8),
        .MIN_DIVISOR (5)
    ) dut (
        .clk       (clk),
        .notreset  (notreset),
        .enable    (enable),
        .divisor   (divisor),
        .data      (data),
        .load      (load),
        .holdempty (holdempty),
        .busy      (busy),
        .overrun   (overrun),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Present a byte for one edge; afterwards the holding register is full
    // and the frame starts on the following edge (when enabled).
    task automatic do_load(input logic [7:0] d);
        @(negedge clk);
        load = 1'b1;
        data = d;
        @(negedge clk);
        load = 1'b0;
        check("he_after_load", holdempty, 32'd0);
        check("tx_after_load", tx, 32'd1);
    endtask

    task automatic idle_check(input int n, input logic exp_he);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_tx", tx, 32'd1);
            check("idle_busy", busy, 32'd0);
            check("idle_he", holdempty, {31'd0, exp_he});
            check("idle_ovr", overrun, 32'd0);
        end
    endtask

    // Check one whole frame cycle by cycle. Optional loads at cycles l1/l2
    // and an optional divisor change at cycle dc (-1 = none).
    task automatic check_frame(input logic [7:0] b, input int bd,
                               input int l1, input logic [7:0] d1,
                               input int l2, input logic [7:0] d2,
                               input int dc, input logic [7:0] nd);
        logic [9:0] fr;
        logic       hold_full;
        logic       ov_pend;
        fr        = {1'b1, b, 1'b0};
        hold_full = 1'b0;
        ov_pend   = 1'b0;
        for (int i = 0; i < 10 * bd; i++) begin
            @(negedge clk);
            check($sformatf("tx_bit%0d_cyc%0d", i / bd, i), tx, {31'd0, fr[i / bd]});
            check("frame_busy", busy, 32'd1);
            check("frame_he", holdempty, {31'd0, !hold_full});
            check("frame_ovr", overrun, {31'd0, ov_pend});
            ov_pend = 1'b0;
            if (i == dc) divisor = nd;
            if (i == l1 || i == l2) begin
                load = 1'b1;
                data = (i == l1) ? d1 : d2;
                if (hold_full) ov_pend = 1'b1;
                else           hold_full = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    initial begin
        notreset = 1'b0;
        enable   = 1'b0;
        divisor  = 8'd5;
        data     = 8'd0;
        load     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx", tx, 32'd1);
        check("rst_he", holdempty, 32'd1);
        check("rst_busy", busy, 32'd0);
        check("rst_ovr", overrun, 32'd0);
        notreset = 1'b1;
        enable   = 1'b1;
        idle_check(3, 1'b1);

        // 0xA5 at divisor 5
        do_load(8'hA5);
        check_frame(8'hA5, 5, -1, 8'h00, -1, 8'h00, -1, 8'h00);
        idle_check(3, 1'b1);

        // divisor below minimum is clamped to 5
        divisor = 8'd3;
        do_load(8'h00);
        check_frame(8'h00, 5, -1, 8'h00, -1, 8'h00, -1, 8'h00);
        idle_check(3, 1'b1);

        // back-to-back frames at divisor 8; third load overruns
        divisor = 8'd8;
        do_load(8'h55);
        check_frame(8'h55, 8, 20, 8'hFF, 30, 8'h12, -1, 8'h00);
        check_frame(8'hFF, 8, -1, 8'h00, -1, 8'h00, -1, 8'h00);
        idle_check(20, 1'b1);

        // divisor change mid-frame applies to the next frame only
        divisor = 8'd6;
        do_load(8'h3C);
        check_frame(8'h3C, 6, 10, 8'hC3, -1, 8'h00, 20, 8'd10);
        check_frame(8'hC3, 10, -1, 8'h00, -1, 8'h00, -1, 8'h00);
        idle_check(3, 1'b1);

        // disabled: byte is held until enable returns
        divisor = 8'd5;
        enable  = 1'b0;
        do_load(8'h5A);
        idle_check(15, 1'b0);
        enable = 1'b1;
        check_frame(8'h5A, 5, -1, 8'h00, -1, 8'h00, -1, 8'h00);
        idle_check(3, 1'b1);

        // asynchronous reset in the middle of DATA with a byte pending
        do_load(8'h00);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            load = (i == 3);
            data = 8'h77;
        end
        load = 1'b0;
        check("pre_rst_tx", tx, 32'd0);
        check("pre_rst_he", holdempty, 32'd0);
        check("pre_rst_busy", busy, 32'd1);
        notreset = 1'b0;
        #1;
        check("arst_tx", tx, 32'd1);
        check("arst_busy", busy, 32'd0);
        check("arst_he", holdempty, 32'd1);
        check("arst_ovr", overrun, 32'd0);
        @(negedge clk);
        notreset = 1'b1;
        idle_check(30, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
